// File: rtl/mem_bus_controller_pkg.sv
`default_nettype none
// ============================================================================
// Package  : mem_bus_controller_pkg
// Brief    : Shared widths, timeout default and FSM encodings for the
//            memory bus sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package mem_bus_controller_pkg;

    localparam int c_WORD_SIZE = 16;
    localparam int c_TIMEOUT   = 255;

    localparam logic [2:0] c_ST_IDLE     = 3'd0;
    localparam logic [2:0] c_ST_RD_INSTR = 3'd1;
    localparam logic [2:0] c_ST_RD_DATA  = 3'd2;
    localparam logic [2:0] c_ST_WR_DATA  = 3'd3;
    localparam logic [2:0] c_ST_RESP     = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE     = c_ST_IDLE,
        ST_RD_INSTR = c_ST_RD_INSTR,
        ST_RD_DATA  = c_ST_RD_DATA,
        ST_WR_DATA  = c_ST_WR_DATA,
        ST_RESP     = c_ST_RESP
    } state_t;

endpackage
`default_nettype wire

// File: rtl/bus_watchdog.sv
`default_nettype none
// ============================================================================
// Module   : bus_watchdog
// Brief    : Cycle counter that flags the last allowed strobe cycle of an
//            access so the sequencer can abort it.
// Revision : 1.0 - initial release
// ============================================================================
module bus_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int               c_CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(TIMEOUT - 1);

    logic [c_CNT_W-1:0] r_count_q;
    logic [c_CNT_W-1:0] w_count_d;

    // Expires while the TIMEOUT-th strobe cycle is in progress.
    assign o_expired = i_enable && (r_count_q == c_LAST);

    always_comb begin
        w_count_d = r_count_q;
        if (i_clear) begin
            w_count_d = '0;
        end else if (i_enable && !o_expired) begin
            w_count_d = r_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count_q <= '0;
        end else begin
            r_count_q <= w_count_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_bus_controller.sv
`default_nettype none
// ============================================================================
// Module   : mem_bus_controller
// Brief    : Serialises core fetch and load/store requests onto the shared
//            readM/writeM memory bus with a watchdog-bounded handshake.
// Revision : 1.0 - initial release
// ============================================================================
module mem_bus_controller
    import mem_bus_controller_pkg::*;
#(
    parameter int WORD_SIZE = c_WORD_SIZE,
    parameter int TIMEOUT   = c_TIMEOUT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 fetch_req,
    input  logic [WORD_SIZE-1:0] fetch_addr,
    output logic                 fetch_done,
    output logic [WORD_SIZE-1:0] instr,
    input  logic                 data_req,
    input  logic                 data_we,
    input  logic [WORD_SIZE-1:0] data_addr,
    input  logic [WORD_SIZE-1:0] data_wdata,
    output logic                 data_done,
    output logic [WORD_SIZE-1:0] data_rdata,
    output logic                 bus_err,
    output logic                 busy,
    output logic                 readM,
    output logic                 writeM,
    output logic [WORD_SIZE-1:0] address,
    inout  wire logic [WORD_SIZE-1:0] data,
    input  logic                 inputReady,
    input  logic                 ackOutput
);

    state_t               r_state_q,      w_state_d;
    logic [WORD_SIZE-1:0] r_addr_q,       w_addr_d;
    logic [WORD_SIZE-1:0] r_wdata_q,      w_wdata_d;
    logic [WORD_SIZE-1:0] r_instr_q,      w_instr_d;
    logic [WORD_SIZE-1:0] r_rdata_q,      w_rdata_d;
    logic                 r_readm_q,      w_readm_d;
    logic                 r_writem_q,     w_writem_d;
    logic                 r_fetch_done_q, w_fetch_done_d;
    logic                 r_data_done_q,  w_data_done_d;
    logic                 r_bus_err_q,    w_bus_err_d;
    logic                 r_busy_q,       w_busy_d;
    logic                 w_wd_clear;
    logic                 w_wd_en;
    logic                 w_wd_expired;

    bus_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk       (clk),
        .rst       (reset),
        .i_clear   (w_wd_clear),
        .i_enable  (w_wd_en),
        .o_expired (w_wd_expired)
    );

    assign fetch_done = r_fetch_done_q;
    assign data_done  = r_data_done_q;
    assign bus_err    = r_bus_err_q;
    assign busy       = r_busy_q;
    assign readM      = r_readm_q;
    assign writeM     = r_writem_q;
    assign address    = r_addr_q;
    assign instr      = r_instr_q;
    assign data_rdata = r_rdata_q;
    assign data       = r_writem_q ? r_wdata_q : {WORD_SIZE{1'bz}};

    // Strobes and pulses are computed for the next state so every output is a flop.
    always_comb begin
        w_state_d      = r_state_q;
        w_addr_d       = r_addr_q;
        w_wdata_d      = r_wdata_q;
        w_instr_d      = r_instr_q;
        w_rdata_d      = r_rdata_q;
        w_readm_d      = 1'b0;
        w_writem_d     = 1'b0;
        w_fetch_done_d = 1'b0;
        w_data_done_d  = 1'b0;
        w_bus_err_d    = 1'b0;
        w_wd_clear     = 1'b0;
        w_wd_en        = 1'b0;

        case (r_state_q)
            ST_IDLE: begin
                if (data_req) begin
                    w_addr_d   = data_addr;
                    w_wd_clear = 1'b1;
                    if (data_we) begin
                        w_state_d  = ST_WR_DATA;
                        w_wdata_d  = data_wdata;
                        w_writem_d = 1'b1;
                    end else begin
                        w_state_d  = ST_RD_DATA;
                        w_readm_d  = 1'b1;
                    end
                end else if (fetch_req) begin
                    w_state_d  = ST_RD_INSTR;
                    w_addr_d   = fetch_addr;
                    w_wd_clear = 1'b1;
                    w_readm_d  = 1'b1;
                end
            end
            ST_RD_INSTR, ST_RD_DATA: begin
                w_wd_en = 1'b1;
                if (inputReady || w_wd_expired) begin
                    w_state_d   = ST_RESP;
                    w_bus_err_d = !inputReady;
                    if (r_state_q == ST_RD_INSTR) begin
                        w_fetch_done_d = 1'b1;
                        if (inputReady) w_instr_d = data;
                    end else begin
                        w_data_done_d = 1'b1;
                        if (inputReady) w_rdata_d = data;
                    end
                end else begin
                    w_readm_d = 1'b1;
                end
            end
            ST_WR_DATA: begin
                w_wd_en = 1'b1;
                if (ackOutput || w_wd_expired) begin
                    w_state_d     = ST_RESP;
                    w_data_done_d = 1'b1;
                    w_bus_err_d   = !ackOutput;
                end else begin
                    w_writem_d = 1'b1;
                end
            end
            ST_RESP: begin
                // Requests still held during the done cycle must not re-issue.
                w_state_d = ST_IDLE;
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase

        w_busy_d = (w_state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state_q      <= ST_IDLE;
            r_addr_q       <= '0;
            r_wdata_q      <= '0;
            r_instr_q      <= '0;
            r_rdata_q      <= '0;
            r_readm_q      <= 1'b0;
            r_writem_q     <= 1'b0;
            r_fetch_done_q <= 1'b0;
            r_data_done_q  <= 1'b0;
            r_bus_err_q    <= 1'b0;
            r_busy_q       <= 1'b0;
        end else begin
            r_state_q      <= w_state_d;
            r_addr_q       <= w_addr_d;
            r_wdata_q      <= w_wdata_d;
            r_instr_q      <= w_instr_d;
            r_rdata_q      <= w_rdata_d;
            r_readm_q      <= w_readm_d;
            r_writem_q     <= w_writem_d;
            r_fetch_done_q <= w_fetch_done_d;
            r_data_done_q  <= w_data_done_d;
            r_bus_err_q    <= w_bus_err_d;
            r_busy_q       <= w_busy_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_bus_controller
// Brief    : Directed scoreboard bench for mem_bus_controller with a
//            configurable-latency memory model (TIMEOUT = 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_bus_controller;

    localparam int c_W = 16;

    typedef struct {
        logic           is_write;
        logic [c_W-1:0] addr;
        logic [c_W-1:0] wdata;
        logic [c_W-1:0] rdata;
        int             delay;   // strobe cycle carrying the handshake; 0 = never
        int             len;     // expected strobe length; -1 = not checked
    } bus_t;

    typedef struct {
        logic           is_fetch;
        logic [c_W-1:0] value;
        logic           err;
    } done_t;

    logic           clk = 1'b0;
    logic           reset;
    logic           fetch_req;
    logic [c_W-1:0] fetch_addr;
    logic           fetch_done;
    logic [c_W-1:0] instr;
    logic           data_req;
    logic           data_we;
    logic [c_W-1:0] data_addr;
    logic [c_W-1:0] data_wdata;
    logic           data_done;
    logic [c_W-1:0] data_rdata;
    logic           bus_err;
    logic           busy;
    logic           readM;
    logic           writeM;
    logic [c_W-1:0] address;
    wire  [c_W-1:0] data_bus;
    logic           inputReady = 1'b0;
    logic           ackOutput  = 1'b0;
    logic           mem_drive  = 1'b0;
    logic [c_W-1:0] mem_dout   = '0;

    int n_tests = 0;
    int n_fail  = 0;

    bus_t  exp_bus[$];
    done_t exp_done[$];
    bus_t  cur;
    bit    in_strobe = 1'b0;
    int    slen = 0;

    logic [c_W-1:0] instr_m;
    logic [c_W-1:0] rdata_m;

    assign data_bus = mem_drive ? mem_dout : {c_W{1'bz}};

    mem_bus_controller #(
        .WORD_SIZE (c_W),
        .TIMEOUT   (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .fetch_req  (fetch_req),
        .fetch_addr (fetch_addr),
        .fetch_done (fetch_done),
        .instr      (instr),
        .data_req   (data_req),
        .data_we    (data_we),
        .data_addr  (data_addr),
        .data_wdata (data_wdata),
        .data_done  (data_done),
        .data_rdata (data_rdata),
        .bus_err    (bus_err),
        .busy       (busy),
        .readM      (readM),
        .writeM     (writeM),
        .address    (address),
        .data       (data_bus),
        .inputReady (inputReady),
        .ackOutput  (ackOutput)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!(fetch_done || data_done) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done_seen"}, 32'(n < 50), 32'd1);
    endtask

    // Memory model and scoreboard monitor, both sampled on the falling edge.
    always @(negedge clk) begin
        inputReady = 1'b0;
        ackOutput  = 1'b0;
        mem_drive  = 1'b0;
        if (!reset && (readM || writeM)) begin
            if (!in_strobe) begin
                in_strobe = 1'b1;
                slen      = 0;
                check("bus_expected", 32'(exp_bus.size() != 0), 32'd1);
                if (exp_bus.size() != 0) cur = exp_bus.pop_front();
                else cur = '{1'b0, 16'h0, 16'h0, 16'h0, 1, -1};
                check("bus_dir", 32'(writeM), 32'(cur.is_write));
                check("bus_addr", 32'(address), 32'(cur.addr));
            end
            slen++;
            if (writeM) check("wr_data", 32'(data_bus), 32'(cur.wdata));
            if (cur.delay != 0 && slen == cur.delay) begin
                if (readM) begin
                    inputReady = 1'b1;
                    mem_dout   = cur.rdata;
                    mem_drive  = 1'b1;
                end else begin
                    ackOutput = 1'b1;
                end
            end
        end else if (in_strobe) begin
            in_strobe = 1'b0;
            if (cur.len >= 0) check("strobe_len", 32'(slen), 32'(cur.len));
        end

        if (fetch_done || data_done || bus_err) begin
            done_t d;
            check("done_expected", 32'(exp_done.size() != 0), 32'd1);
            if (exp_done.size() != 0) begin
                d = exp_done.pop_front();
                check("done_fetch", 32'(fetch_done), 32'(d.is_fetch));
                check("done_data", 32'(data_done), 32'(!d.is_fetch));
                check("done_err", 32'(bus_err), 32'(d.err));
                check("done_value", 32'(d.is_fetch ? instr : data_rdata), 32'(d.value));
            end
        end
    end

    initial begin
        reset      = 1'b1;
        fetch_req  = 1'b0;
        fetch_addr = '0;
        data_req   = 1'b0;
        data_we    = 1'b0;
        data_addr  = '0;
        data_wdata = '0;
        instr_m    = '0;
        rdata_m    = '0;

        repeat (3) @(negedge clk);
        check("rst_readM", 32'(readM), 32'd0);
        check("rst_writeM", 32'(writeM), 32'd0);
        check("rst_fetch_done", 32'(fetch_done), 32'd0);
        check("rst_data_done", 32'(data_done), 32'd0);
        check("rst_bus_err", 32'(bus_err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_address", 32'(address), 32'd0);
        check("rst_instr", 32'(instr), 32'd0);
        check("rst_rdata", 32'(data_rdata), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Fetch with two-cycle memory latency.
        instr_m = 16'h6A05;
        exp_bus.push_back('{1'b0, 16'h0010, 16'h0, 16'h6A05, 2, 2});
        exp_done.push_back('{1'b1, instr_m, 1'b0});
        fetch_addr = 16'h0010;
        fetch_req  = 1'b1;
        @(negedge clk);
        check("fetch_busy_rise", 32'(busy), 32'd1);
        check("fetch_readM", 32'(readM), 32'd1);
        wait_done("fetch1");
        fetch_req  = 1'b0;
        fetch_addr = 16'hFFFF;
        @(negedge clk);
        check("fetch_busy_fall", 32'(busy), 32'd0);
        check("fetch_instr", 32'(instr), 32'h6A05);

        // Store acknowledged in its first strobe cycle.
        exp_bus.push_back('{1'b1, 16'h0020, 16'h1234, 16'h0, 1, 1});
        exp_done.push_back('{1'b0, rdata_m, 1'b0});
        data_addr  = 16'h0020;
        data_wdata = 16'h1234;
        data_we    = 1'b1;
        data_req   = 1'b1;
        @(negedge clk);
        data_wdata = 16'hDEAD;
        wait_done("store");
        data_req = 1'b0;
        data_we  = 1'b0;
        @(negedge clk);
        check("store_writeM_low", 32'(writeM), 32'd0);

        // Simultaneous load and fetch: the load wins.
        rdata_m = 16'hBEEF;
        instr_m = 16'h1111;
        exp_bus.push_back('{1'b0, 16'h0030, 16'h0, 16'hBEEF, 1, 1});
        exp_bus.push_back('{1'b0, 16'h0040, 16'h0, 16'h1111, 1, 1});
        exp_done.push_back('{1'b0, 16'hBEEF, 1'b0});
        exp_done.push_back('{1'b1, 16'h1111, 1'b0});
        data_addr  = 16'h0030;
        fetch_addr = 16'h0040;
        data_req   = 1'b1;
        fetch_req  = 1'b1;
        @(negedge clk);
        wait_done("prio_load");
        check("prio_data_first", 32'(data_done), 32'd1);
        data_req = 1'b0;
        @(negedge clk);
        wait_done("prio_fetch");
        fetch_req = 1'b0;
        @(negedge clk);

        // Request held across the edge that ends the done cycle.
        instr_m = 16'h2222;
        exp_bus.push_back('{1'b0, 16'h0050, 16'h0, 16'h2222, 1, 1});
        exp_done.push_back('{1'b1, 16'h2222, 1'b0});
        fetch_addr = 16'h0050;
        fetch_req  = 1'b1;
        @(negedge clk);
        wait_done("hold");
        @(posedge clk);
        #1 fetch_req = 1'b0;
        repeat (3) @(negedge clk);
        check("hold_no_dup", 32'(exp_bus.size()), 32'd0);

        rdata_m = 16'h3333;
        exp_bus.push_back('{1'b0, 16'h0060, 16'h0, 16'h3333, 2, 2});
        exp_done.push_back('{1'b0, 16'h3333, 1'b0});
        data_addr = 16'h0060;
        data_req  = 1'b1;
        @(negedge clk);
        wait_done("load2");
        data_req = 1'b0;
        @(negedge clk);

        // Load with no response: watchdog aborts after four strobe cycles.
        exp_bus.push_back('{1'b0, 16'h0070, 16'h0, 16'h0, 0, 4});
        exp_done.push_back('{1'b0, rdata_m, 1'b1});
        data_addr = 16'h0070;
        data_req  = 1'b1;
        @(negedge clk);
        wait_done("timeout");
        check("timeout_err", 32'(bus_err), 32'd1);
        data_req = 1'b0;
        @(negedge clk);
        check("timeout_rdata", 32'(data_rdata), 32'h3333);

        // Reset in the middle of a read aborts it silently.
        exp_bus.push_back('{1'b0, 16'h0080, 16'h0, 16'h0, 0, -1});
        fetch_addr = 16'h0080;
        fetch_req  = 1'b1;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("midrst_readM", 32'(readM), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        fetch_req = 1'b0;
        instr_m   = '0;
        rdata_m   = '0;
        repeat (2) begin
            @(negedge clk);
            check("midrst_no_done", 32'(fetch_done), 32'd0);
        end
        reset = 1'b0;
        @(negedge clk);

        instr_m = 16'h4444;
        exp_bus.push_back('{1'b0, 16'h0090, 16'h0, 16'h4444, 3, 3});
        exp_done.push_back('{1'b1, 16'h4444, 1'b0});
        fetch_addr = 16'h0090;
        fetch_req  = 1'b1;
        @(negedge clk);
        wait_done("post_rst_fetch");
        fetch_req = 1'b0;
        @(negedge clk);
        check("post_rst_instr", 32'(instr), 32'h4444);

        repeat (3) @(negedge clk);
        check("bus_queue_drained", 32'(exp_bus.size()), 32'd0);
        check("done_queue_drained", 32'(exp_done.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
